db_edge_param_ctrl: RTL and testbench

- Deblocking edge-parameter scheduler for one LCU.
- On start, walks every 8x8 edge of the LCU: all vertical edges first, then all horizontal edges, each pass in raster order.
- For each edge it reads the Q-side and P-side block info (qp, intra flag, bS) from the LCU info memory, then computes the average qp, bS and tc.
- Emits one parameter record per filterable edge to the luma filter datapath over a valid/ready handshake.

---
 rtl/db_edge_param_ctrl_pkg.sv | 27 ++
 rtl/db_tc_table.sv | 42 ++++
 rtl/db_edge_param_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_db_edge_param_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/db_edge_param_ctrl_pkg.sv
// Shared deblocking definitions: FSM encoding, qp/tc-index limits, intra bS.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package db_edge_param_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_Q = 3'd1,
        S_RD_P = 3'd2,
        S_CALC = 3'd3,
        S_OUT  = 3'd4,
        S_NEXT = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam logic [5:0] QP_MAX     = 6'd51;
    localparam logic [5:0] TC_IDX_MAX = 6'd53;
    localparam logic [1:0] BS_INTRA   = 2'd2;

    // Rounded average of two qps; the 7-bit sum cannot overflow for 6-bit inputs.
    function automatic logic [5:0] qp_avg(input logic [5:0] qp_a, input logic [5:0] qp_b);
        logic [6:0] sum;
        sum = {1'b0, qp_a} + {1'b0, qp_b} + 7'd1;
        return sum[6:1];
    endfunction

endpackage

// File: rtl/db_tc_table.sv
// HEVC luma tc lookup indexed by the clamped qp+offset index (0..53).
// Latency: purely combinational.
// Backpressure: none; indices above 53 return the top-of-table value.
module db_tc_table (
    input  logic [5:0] idx,
    output logic [4:0] tc
);

    // Flat segments of the table by range, the steep tail enumerated.
    always_comb begin
        tc = 5'd0;
        if (idx >= 6'd42) begin
            case (idx)
                6'd42:   tc = 5'd7;
                6'd43:   tc = 5'd8;
                6'd44:   tc = 5'd9;
                6'd45:   tc = 5'd10;
                6'd46:   tc = 5'd11;
                6'd47:   tc = 5'd13;
                6'd48:   tc = 5'd14;
                6'd49:   tc = 5'd16;
                6'd50:   tc = 5'd18;
                6'd51:   tc = 5'd20;
                6'd52:   tc = 5'd22;
                default: tc = 5'd24;
            endcase
        end else if (idx >= 6'd40) begin
            tc = 5'd6;
        end else if (idx >= 6'd38) begin
            tc = 5'd5;
        end else if (idx >= 6'd35) begin
            tc = 5'd4;
        end else if (idx >= 6'd31) begin
            tc = 5'd3;
        end else if (idx >= 6'd27) begin
            tc = 5'd2;
        end else if (idx >= 6'd18) begin
            tc = 5'd1;
        end
    end

endmodule

// File: rtl/db_edge_param_ctrl.sv
// Deblocking edge scheduler: walks all 8x8 edges of an LCU (vertical then horizontal, raster) and emits bS/qp/tc records.
// Latency: first record valid 4 cycles after start; 5 cycles per emitted edge, 2 per border skip, 3 per bS=0 skip.
// Backpressure: record held stable in OUT until edge_ready_i; no reads issued while stalled. Optional DB_TC_OFFSET_EN adds tc_offset_div2_i.
module db_edge_param_ctrl
    import db_edge_param_ctrl_pkg::*;
#(
    parameter int LCU_BLK = 8,
    parameter int CNT_W   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             pic_left_i,
    input  logic             pic_top_i,
    output logic             rd_en_o,
    output logic [CNT_W:0]   rd_x_o,
    output logic [CNT_W:0]   rd_y_o,
    input  logic [5:0]       rd_qp_i,
    input  logic             rd_intra_i,
    input  logic [1:0]       rd_bs_v_i,
    input  logic [1:0]       rd_bs_h_i,
    output logic             edge_valid_o,
    input  logic             edge_ready_i,
`ifdef DB_TC_OFFSET_EN
    input  logic [3:0]       tc_offset_div2_i,
`endif
    output logic             edge_dir_o,
    output logic [CNT_W-1:0] edge_x_o,
    output logic [CNT_W-1:0] edge_y_o,
    output logic [1:0]       edge_bs_o,
    output logic [5:0]       edge_qp_o,
    output logic [4:0]       edge_tc_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LCU_BLK - 1);

    state_t            state, state_nxt;
    logic              dir;
    logic [CNT_W-1:0]  x_cnt, y_cnt;
    logic              pic_left_q, pic_top_q;
    logic [5:0]        q_qp;
    logic              q_intra;
    logic [1:0]        q_bs;

    logic              is_border;
    logic [1:0]        rd_bs_sel;
    logic [CNT_W:0]    q_x, q_y, p_x, p_y;
    logic [1:0]        bs_calc;
    logic [5:0]        qp_calc;
    logic signed [7:0] tc_off2;
    logic signed [7:0] idx_raw;
    logic [5:0]        idx_sat;
    logic [4:0]        tc_calc;

    // Edge geometry: border test, bS direction select, Q and P block addresses.
    always_comb begin
        is_border = dir ? ((y_cnt == '0) && pic_top_q) : ((x_cnt == '0) && pic_left_q);
        rd_bs_sel = dir ? rd_bs_h_i : rd_bs_v_i;
        q_x       = {1'b0, x_cnt};
        q_y       = {1'b0, y_cnt};
        p_x       = dir ? q_x : q_x - (CNT_W+1)'(1);
        p_y       = dir ? q_y - (CNT_W+1)'(1) : q_y;
    end

`ifdef DB_TC_OFFSET_EN
    assign tc_off2 = {{3{tc_offset_div2_i[3]}}, tc_offset_div2_i, 1'b0};
`else
    assign tc_off2 = 8'sd0;
`endif

    // Edge parameters from the captured Q side and the P side on the read bus.
    always_comb begin
        bs_calc = (q_intra || rd_intra_i) ? BS_INTRA : q_bs;
        qp_calc = qp_avg(q_qp, rd_qp_i);
        idx_raw = $signed({2'b00, qp_calc}) + ((bs_calc == BS_INTRA) ? 8'sd2 : 8'sd0) + tc_off2;
        if (idx_raw < 8'sd0) begin
            idx_sat = 6'd0;
        end else if (idx_raw > $signed({2'b00, TC_IDX_MAX})) begin
            idx_sat = TC_IDX_MAX;
        end else begin
            idx_sat = idx_raw[5:0];
        end
    end

    db_tc_table u_tc_table (
        .idx (idx_sat),
        .tc  (tc_calc)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs; at most one read strobe per cycle.
    always_comb begin
        state_nxt    = state;
        rd_en_o      = 1'b0;
        rd_x_o       = '0;
        rd_y_o       = '0;
        edge_valid_o = 1'b0;
        busy_o       = 1'b1;
        done_o       = 1'b0;
        case (state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_nxt = S_RD_Q;
                end
            end
            S_RD_Q: begin
                if (is_border) begin
                    state_nxt = S_NEXT;
                end else begin
                    rd_en_o   = 1'b1;
                    rd_x_o    = q_x;
                    rd_y_o    = q_y;
                    state_nxt = S_RD_P;
                end
            end
            S_RD_P: begin
                if (rd_bs_sel == 2'd0) begin
                    state_nxt = S_NEXT;
                end else begin
                    rd_en_o   = 1'b1;
                    rd_x_o    = p_x;
                    rd_y_o    = p_y;
                    state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                state_nxt = S_OUT;
            end
            S_OUT: begin
                edge_valid_o = 1'b1;
                if (edge_ready_i) begin
                    state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                if (dir && (x_cnt == CNT_LAST) && (y_cnt == CNT_LAST)) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_RD_Q;
                end
            end
            S_DONE: begin
                busy_o    = 1'b0;
                done_o    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                busy_o    = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Edge walk counters, border flags, Q capture and the output record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir        <= 1'b0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            pic_left_q <= 1'b0;
            pic_top_q  <= 1'b0;
            q_qp       <= '0;
            q_intra    <= 1'b0;
            q_bs       <= '0;
            edge_dir_o <= 1'b0;
            edge_x_o   <= '0;
            edge_y_o   <= '0;
            edge_bs_o  <= '0;
            edge_qp_o  <= '0;
            edge_tc_o  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        pic_left_q <= pic_left_i;
                        pic_top_q  <= pic_top_i;
                        dir        <= 1'b0;
                        x_cnt      <= '0;
                        y_cnt      <= '0;
                    end
                end
                S_RD_P: begin
                    q_qp    <= rd_qp_i;
                    q_intra <= rd_intra_i;
                    q_bs    <= rd_bs_sel;
                end
                S_CALC: begin
                    edge_dir_o <= dir;
                    edge_x_o   <= x_cnt;
                    edge_y_o   <= y_cnt;
                    edge_bs_o  <= bs_calc;
                    edge_qp_o  <= qp_calc;
                    edge_tc_o  <= tc_calc;
                end
                S_NEXT: begin
                    if (x_cnt == CNT_LAST) begin
                        x_cnt <= '0;
                        if (y_cnt == CNT_LAST) begin
                            if (!dir) begin
                                y_cnt <= '0;
                                dir   <= 1'b1;
                            end
                        end else begin
                            y_cnt <= y_cnt + CNT_W'(1);
                        end
                    end else begin
                        x_cnt <= x_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_db_edge_param_ctrl.sv
// Directed bench for db_edge_param_ctrl with a 1-cycle-latency info memory model.
// Records are collected at each valid&ready handshake and compared to hand-computed values.
// Stalls, border/zero-bS skips, timing and mid-LCU reset are driven from one initial block.
module tb_db_edge_param_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i, pic_left_i, pic_top_i;
    logic       rd_en_o;
    logic [3:0] rd_x_o, rd_y_o;
    logic [5:0] rd_qp_i;
    logic       rd_intra_i;
    logic [1:0] rd_bs_v_i, rd_bs_h_i;
    logic       edge_valid_o, edge_ready_i, edge_dir_o;
    logic [2:0] edge_x_o, edge_y_o;
    logic [1:0] edge_bs_o;
    logic [5:0] edge_qp_o;
    logic [4:0] edge_tc_o;
    logic       busy_o, done_o;
`ifdef DB_TC_OFFSET_EN
    logic [3:0] tc_offset_div2_i;
`endif

    always #5 clk = ~clk;

    db_edge_param_ctrl #(.LCU_BLK(8), .CNT_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .pic_left_i   (pic_left_i),
        .pic_top_i    (pic_top_i),
        .rd_en_o      (rd_en_o),
        .rd_x_o       (rd_x_o),
        .rd_y_o       (rd_y_o),
        .rd_qp_i      (rd_qp_i),
        .rd_intra_i   (rd_intra_i),
        .rd_bs_v_i    (rd_bs_v_i),
        .rd_bs_h_i    (rd_bs_h_i),
        .edge_valid_o (edge_valid_o),
        .edge_ready_i (edge_ready_i),
`ifdef DB_TC_OFFSET_EN
        .tc_offset_div2_i (tc_offset_div2_i),
`endif
        .edge_dir_o   (edge_dir_o),
        .edge_x_o     (edge_x_o),
        .edge_y_o     (edge_y_o),
        .edge_bs_o    (edge_bs_o),
        .edge_qp_o    (edge_qp_o),
        .edge_tc_o    (edge_tc_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    // Info memory indexed [x+1][y+1] so that -1 (neighbour LCU) maps to 0.
    logic [5:0] mem_qp    [0:8][0:8];
    logic       mem_intra [0:8][0:8];
    logic [1:0] mem_bs_v  [0:8][0:8];
    logic [1:0] mem_bs_h  [0:8][0:8];

    logic [19:0] rec_q[$];
    int          rd_cnt   = 0;
    int          done_cnt = 0;
    int          tests    = 0;
    int          fails    = 0;
    int          r_busy, r_done, r_first, stall_bad;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_qp_i    <= '0;
            rd_intra_i <= 1'b0;
            rd_bs_v_i  <= '0;
            rd_bs_h_i  <= '0;
        end else if (rd_en_o) begin
            rd_qp_i    <= mem_qp   [$signed(rd_x_o) + 1][$signed(rd_y_o) + 1];
            rd_intra_i <= mem_intra[$signed(rd_x_o) + 1][$signed(rd_y_o) + 1];
            rd_bs_v_i  <= mem_bs_v [$signed(rd_x_o) + 1][$signed(rd_y_o) + 1];
            rd_bs_h_i  <= mem_bs_h [$signed(rd_x_o) + 1][$signed(rd_y_o) + 1];
        end
    end

    always @(posedge clk) begin
        if (rst_n && edge_valid_o && edge_ready_i)
            rec_q.push_back({edge_dir_o, edge_x_o, edge_y_o, edge_bs_o, edge_qp_o, edge_tc_o});
        if (rst_n && rd_en_o) rd_cnt++;
        if (rst_n && done_o) done_cnt++;
    end

    function automatic logic [19:0] mk_rec(input int d, input int x, input int y,
                                           input int bs, input int qp, input int tc);
        return {1'(d), 3'(x), 3'(y), 2'(bs), 6'(qp), 5'(tc)};
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input int qp, input int bs);
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 9; j++) begin
                mem_qp[i][j]    = 6'(qp);
                mem_intra[i][j] = 1'b0;
                mem_bs_v[i][j]  = 2'(bs);
                mem_bs_h[i][j]  = 2'(bs);
            end
        end
    endtask

    task automatic set_blk(input int x, input int y, input int qp, input int intra,
                           input int bsv, input int bsh);
        mem_qp[x+1][y+1]    = 6'(qp);
        mem_intra[x+1][y+1] = 1'(intra);
        mem_bs_v[x+1][y+1]  = 2'(bsv);
        mem_bs_h[x+1][y+1]  = 2'(bsh);
    endtask

    // Cycle 0 is the cycle start_i is high; observations are taken at each negedge.
    task automatic run_lcu(input logic left, input logic top, input int stall_at, input int abort_at);
        logic [19:0] snap;
        int          stall_left;
        rec_q.delete();
        rd_cnt     = 0;
        r_busy     = 0;
        r_done     = -1;
        r_first    = -1;
        stall_bad  = 0;
        stall_left = 10;
        snap       = '0;
        pic_left_i = left;
        pic_top_i  = top;
        start_i    = 1'b1;
        @(negedge clk);
        start_i    = 1'b0;
        for (int c = 1; c < 3000 && r_done < 0; c++) begin
            if (busy_o) r_busy++;
            if (done_o) r_done = c;
            if (edge_valid_o && r_first < 0) r_first = c;
            if (abort_at >= 0 && edge_valid_o && rec_q.size() == abort_at) begin
                rst_n = 1'b0;
                break;
            end
            if (stall_at >= 0 && edge_valid_o && rec_q.size() == stall_at && stall_left > 0) begin
                edge_ready_i = 1'b0;
                if (stall_left == 10)
                    snap = {edge_dir_o, edge_x_o, edge_y_o, edge_bs_o, edge_qp_o, edge_tc_o};
                else if (snap !== {edge_dir_o, edge_x_o, edge_y_o, edge_bs_o, edge_qp_o, edge_tc_o})
                    stall_bad++;
                if (rd_en_o) stall_bad++;
                stall_left--;
            end else begin
                edge_ready_i = 1'b1;
            end
            @(negedge clk);
        end
        edge_ready_i = 1'b1;
    endtask

    // Full LCU with uniform qp and bS=1 and no borders: vertical raster then horizontal raster.
    task automatic chk_full(input string tag, input int qp, input int tc);
        int errs;
        errs = 0;
        chk({tag, "_count"}, rec_q.size(), 128);
        for (int k = 0; k < rec_q.size() && k < 128; k++)
            if (rec_q[k] !== mk_rec(k / 64, k % 8, (k % 64) / 8, 1, qp, tc)) errs++;
        chk({tag, "_order"}, errs, 0);
    endtask

    initial begin
        int bad;
        int done_before;
        rst_n        = 1'b0;
        start_i      = 1'b0;
        pic_left_i   = 1'b0;
        pic_top_i    = 1'b0;
        edge_ready_i = 1'b1;
`ifdef DB_TC_OFFSET_EN
        tc_offset_div2_i = 4'd0;
`endif
        fill(0, 0);
        repeat (3) @(negedge clk);
        chk("rst_valid", edge_valid_o, 0);
        chk("rst_busy",  busy_o, 0);
        chk("rst_done",  done_o, 0);
        chk("rst_rd_en", rd_en_o, 0);
        chk("rst_rec",   {edge_dir_o, edge_x_o, edge_y_o, edge_bs_o, edge_qp_o, edge_tc_o}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single inter edge at (0,0): (30+32+1)>>1 = 31, idx 31 -> tc 3.
        fill(0, 0);
        set_blk(0, 0, 32, 0, 1, 0);
        set_blk(-1, 0, 30, 0, 0, 0);
        run_lcu(1'b0, 1'b0, -1, -1);
        chk("inter_count", rec_q.size(), 1);
        chk("inter_rec", rec_q.size() > 0 ? rec_q[0] : 20'hfffff, mk_rec(0, 0, 0, 1, 31, 3));
        chk("inter_first_valid_cycle", r_first, 4);
        chk("inter_done_seen", r_done > 0, 1);

        // Intra, saturation, rounding and tc-range boundaries.
        fill(0, 0);
        set_blk(0, 0, 37, 0, 1, 0);
        set_blk(-1, 0, 36, 1, 0, 0);
        set_blk(0, 1, 51, 1, 1, 0);
        set_blk(-1, 1, 51, 0, 0, 0);
        set_blk(2, 3, 18, 0, 0, 1);
        set_blk(2, 2, 17, 0, 0, 0);
        set_blk(3, 3, 17, 0, 0, 1);
        set_blk(3, 2, 17, 0, 0, 0);
        set_blk(4, 4, 40, 0, 0, 2);
        set_blk(4, 3, 40, 0, 0, 0);
        run_lcu(1'b0, 1'b0, -1, -1);
        chk("mix_count", rec_q.size(), 5);
        if (rec_q.size() == 5) begin
            chk("intra_p_idx39",     rec_q[0], mk_rec(0, 0, 0, 2, 37, 5));
            chk("intra_q_sat53",     rec_q[1], mk_rec(0, 0, 1, 2, 51, 24));
            chk("round_idx18",       rec_q[2], mk_rec(1, 2, 3, 1, 18, 1));
            chk("idx17_tc0",         rec_q[3], mk_rec(1, 3, 3, 1, 17, 0));
            chk("bs2_noint_idx42",   rec_q[4], mk_rec(1, 4, 4, 2, 40, 7));
        end

        // Both picture borders: 16 skipped edges, 112 records, qp 20 -> tc 1.
        fill(20, 1);
        run_lcu(1'b1, 1'b1, -1, -1);
        chk("border_count", rec_q.size(), 112);
        bad = 0;
        foreach (rec_q[k]) begin
            if ((rec_q[k][19] == 1'b0 && rec_q[k][18:16] == 3'd0) ||
                (rec_q[k][19] == 1'b1 && rec_q[k][15:13] == 3'd0) ||
                rec_q[k][4:0] != 5'd1) bad++;
        end
        chk("border_bad_recs", bad, 0);
        chk("border_busy_cycles", r_busy, 16 * 2 + 112 * 5);

        // All bS=0: no records, 3 cycles per edge, done still pulses.
        fill(20, 0);
        run_lcu(1'b0, 1'b0, -1, -1);
        chk("zero_count", rec_q.size(), 0);
        chk("zero_done_cycle", r_done, 128 * 3 + 1);
        chk("zero_busy_cycles", r_busy, 128 * 3);

        // Full LCU with ready high: busy spans 128 x 5 = 640 cycles, done in the next.
        fill(20, 1);
        run_lcu(1'b0, 1'b0, -1, -1);
        chk_full("full", 20, 1);
        chk("full_busy_cycles", r_busy, 640);
        chk("full_done_cycle", r_done, 641);
        chk("full_reads", rd_cnt, 256);

        // Ready low for 10 cycles on record 5.
        fill(25, 1);
        run_lcu(1'b0, 1'b0, 5, -1);
        chk_full("bp", 25, 1);
        chk("bp_stall_hold", stall_bad, 0);
        chk("bp_busy_cycles", r_busy, 650);
        chk("bp_reads", rd_cnt, 256);

        // Reset while record 40 is offered, then a clean restart.
        fill(20, 1);
        done_before = done_cnt;
        run_lcu(1'b0, 1'b0, -1, 40);
        #1;
        chk("abort_valid_drop", edge_valid_o, 0);
        chk("abort_busy_drop", busy_o, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_done", done_cnt, done_before);
        run_lcu(1'b0, 1'b0, -1, -1);
        chk_full("restart", 20, 1);

`ifdef DB_TC_OFFSET_EN
        // Offset +2 on the inter edge: idx 31 + 4 = 35 -> tc 4.
        fill(0, 0);
        set_blk(0, 0, 32, 0, 1, 0);
        set_blk(-1, 0, 30, 0, 0, 0);
        tc_offset_div2_i = 4'd2;
        run_lcu(1'b0, 1'b0, -1, -1);
        chk("offset_count", rec_q.size(), 1);
        chk("offset_rec", rec_q.size() > 0 ? rec_q[0] : 20'hfffff, mk_rec(0, 0, 0, 1, 31, 4));
        tc_offset_div2_i = 4'd0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
